// File: rtl/apu_noise_div_ctrl.sv
// Noise channel period divider with a 15-bit LFSR.
// Ports: CLK/rst, en strobe, run enable, register write (wr, wr_period, wr_mode); tick, rnd, lfsr, cnt.
module apu_noise_div_ctrl #(
  parameter bit RELOAD_ON_WRITE = 1'b0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        en,
  input  logic        run,
  input  logic        wr,
  input  logic [3:0]  wr_period,
  input  logic        wr_mode,
  output logic        tick,
  output logic        rnd,
  output logic [14:0] lfsr,
  output logic [10:0] cnt
);

  typedef enum logic {
    ST_STOP,
    ST_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  period_q, period_d;
  logic        mode_q, mode_d;
  logic [10:0] cnt_d;
  logic [14:0] lfsr_d;
  logic        tick_d;
  logic        wrap;
  logic        fb;

  function automatic logic [10:0] reload(input logic [3:0] idx);
    logic [10:0] r;
    case (idx)
      4'd0:    r = 11'd1;
      4'd1:    r = 11'd3;
      4'd2:    r = 11'd7;
      4'd3:    r = 11'd15;
      4'd4:    r = 11'd31;
      4'd5:    r = 11'd47;
      4'd6:    r = 11'd63;
      4'd7:    r = 11'd79;
      4'd8:    r = 11'd100;
      4'd9:    r = 11'd126;
      4'd10:   r = 11'd189;
      4'd11:   r = 11'd253;
      4'd12:   r = 11'd380;
      4'd13:   r = 11'd507;
      4'd14:   r = 11'd1016;
      default: r = 11'd2033;
    endcase
    return r;
  endfunction

  assign rnd  = lfsr[0];
  assign wrap = en && (cnt == 11'd0);
  // The step always uses the mode in force before any coincident write.
  assign fb   = lfsr[0] ^ (mode_q ? lfsr[6] : lfsr[1]);

  always_comb begin
    state_d  = state_q;
    period_d = wr ? wr_period : period_q;
    mode_d   = wr ? wr_mode : mode_q;
    cnt_d    = cnt;
    lfsr_d   = lfsr;
    tick_d   = 1'b0;
    case (state_q)
      ST_STOP: begin
        cnt_d = reload(period_d);
        if (run) state_d = ST_RUN;
      end
      default: begin
        if (!run) begin
          // Stopping takes priority over a simultaneous wrap.
          state_d = ST_STOP;
          cnt_d   = reload(period_d);
        end else if (wrap) begin
          cnt_d  = reload(period_d);
          lfsr_d = {fb, lfsr[14:1]};
          tick_d = 1'b1;
        end else if (wr && RELOAD_ON_WRITE) begin
          cnt_d = reload(wr_period);
        end else if (en) begin
          cnt_d = cnt - 11'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STOP;
      period_q <= 4'd0;
      mode_q   <= 1'b0;
      cnt      <= 11'd1;
      lfsr     <= 15'h0001;
      tick     <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      cnt      <= cnt_d;
      lfsr     <= lfsr_d;
      tick     <= tick_d;
    end
  end

endmodule

// File: tb/tb_apu_noise_div_ctrl.sv
// Scoreboard bench for apu_noise_div_ctrl, both reload-on-write variants.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_apu_noise_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, en, wr, wm;
  logic [3:0]  wp;
  logic        tick0, rnd0, tick1, rnd1;
  logic [14:0] lfsr0, lfsr1;
  logic [10:0] cnt0, cnt1;

  apu_noise_div_ctrl #(.RELOAD_ON_WRITE(1'b0)) dut0 (
    .CLK(clk), .rst(rst), .en(en), .run(run), .wr(wr),
    .wr_period(wp), .wr_mode(wm),
    .tick(tick0), .rnd(rnd0), .lfsr(lfsr0), .cnt(cnt0)
  );

  apu_noise_div_ctrl #(.RELOAD_ON_WRITE(1'b1)) dut1 (
    .CLK(clk), .rst(rst), .en(en), .run(run), .wr(wr),
    .wr_period(wp), .wr_mode(wm),
    .tick(tick1), .rnd(rnd1), .lfsr(lfsr1), .cnt(cnt1)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        t;
    logic [14:0] l;
    logic [10:0] c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tbl[16] = '{1, 3, 7, 15, 31, 47, 63, 79,
                  100, 126, 189, 253, 380, 507, 1016, 2033};

  bit m_on[2];
  int m_per[2];
  bit m_mode[2];
  int m_cnt[2];
  int m_lfsr[2];
  bit m_tick[2];

  int vecs = 0;
  int miscompares = 0;
  int exp_gap = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input int exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_on[k]   = 1'b0;
      m_per[k]  = 0;
      m_mode[k] = 1'b0;
      m_cnt[k]  = 1;
      m_lfsr[k] = 1;
      m_tick[k] = 1'b0;
    end
  endtask

  function automatic int lfsr_next(input int l, input bit md);
    int fb;
    fb = (l ^ (l >> (md ? 6 : 1))) & 1;
    return (l >> 1) | (fb << 14);
  endfunction

  // Expected state after the coming clock edge.
  task automatic model_step(input int k, input bit ru, input bit e,
                            input bit w, input int p, input bit md);
    int np;
    bit nm;
    bit t;
    np = w ? p : m_per[k];
    nm = w ? md : m_mode[k];
    t  = 1'b0;
    if (!m_on[k]) begin
      m_cnt[k] = tbl[np];
      m_on[k]  = ru;
    end else if (!ru) begin
      m_on[k]  = 1'b0;
      m_cnt[k] = tbl[np];
    end else if (e && m_cnt[k] == 0) begin
      m_lfsr[k] = lfsr_next(m_lfsr[k], m_mode[k]);
      m_cnt[k]  = tbl[np];
      t = 1'b1;
    end else if (w && k == 1) begin
      m_cnt[k] = tbl[p];
    end else if (e) begin
      m_cnt[k] = m_cnt[k] - 1;
    end
    m_per[k]  = np;
    m_mode[k] = nm;
    m_tick[k] = t;
  endtask

  task automatic cycle(input bit r, input bit ru, input bit e,
                       input bit w, input int p, input bit md);
    exp_t x;
    @(negedge clk);
    rst = r;
    run = ru;
    en  = e;
    wr  = w;
    wp  = 4'(p);
    wm  = md;
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) model_step(k, ru, e, w, p, md);
    end
    x.t = m_tick[0];
    x.l = 15'(m_lfsr[0]);
    x.c = 11'(m_cnt[0]);
    q0.push_back(x);
    x.t = m_tick[1];
    x.l = 15'(m_lfsr[1]);
    x.c = 11'(m_cnt[1]);
    q1.push_back(x);
  endtask

  // Monitor: one output sample per clock, compared against the queue.
  initial begin
    exp_t e;
    int cyc = 0;
    int last = -1;
    int prev_cfg = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("tick0", 32'(tick0), int'(e.t));
        chk("lfsr0", 32'(lfsr0), int'(e.l));
        chk("cnt0", 32'(cnt0), int'(e.c));
        chk("rnd0", 32'(rnd0), int'(e.l[0]));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("tick1", 32'(tick1), int'(e.t));
        chk("lfsr1", 32'(lfsr1), int'(e.l));
        chk("cnt1", 32'(cnt1), int'(e.c));
        chk("rnd1", 32'(rnd1), int'(e.l[0]));
      end
      if (exp_gap != prev_cfg) begin
        last = -1;
        prev_cfg = exp_gap;
      end
      if (tick0 === 1'b1 && exp_gap != 0) begin
        if (last >= 0) chk("tick_gap", 32'(cyc - last), exp_gap);
        last = cyc;
      end
      cyc++;
    end
  end

  task automatic miss(input string nm);
    miscompares++;
    $display("FAIL %s target count not reached", nm);
  endtask

  initial begin
    bit hit;
    bit r, ru, e, w, md;
    int p;
    rst = 1'b1;
    run = 1'b0;
    en  = 1'b0;
    wr  = 1'b0;
    wp  = 4'd0;
    wm  = 1'b0;
    model_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Fastest period: tick every second cycle.
    repeat (12) cycle(0, 1, 1, 0, 0, 0);

    // Slowest period, continuous then half-rate enable.
    cycle(0, 0, 0, 1, 15, 0);
    exp_gap = 2034;
    repeat (4200) cycle(0, 1, 1, 0, 0, 0);
    exp_gap = 4068;
    for (int i = 0; i < 9000; i++) cycle(0, 1, (i % 2) == 0, 0, 0, 0);
    exp_gap = 0;

    // Period rewrite mid-count.
    cycle(0, 0, 0, 1, 4, 0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_on[0] && m_cnt[0] == 20) hit = 1'b1;
      else cycle(0, 1, 1, 0, 0, 0);
    end
    if (!hit) miss("cnt20");
    cycle(0, 1, 1, 1, 0, 0);
    repeat (40) cycle(0, 1, 1, 0, 0, 0);

    // Write landing exactly on a wrap.
    cycle(0, 0, 0, 1, 2, 0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_on[0] && m_cnt[0] == 0) hit = 1'b1;
      else cycle(0, 1, 1, 0, 0, 0);
    end
    if (!hit) miss("wrap_write");
    cycle(0, 1, 1, 1, 1, 1);
    repeat (20) cycle(0, 1, 1, 0, 0, 0);

    // Asynchronous reset mid-count.
    cycle(0, 0, 0, 1, 13, 0);
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_on[0] && m_cnt[0] == 500) hit = 1'b1;
      else cycle(0, 1, 1, 0, 0, 0);
    end
    if (!hit) miss("cnt500");
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_cnt0", 32'(cnt0), 1);
    chk("async_lfsr0", 32'(lfsr0), 1);
    chk("async_tick0", 32'(tick0), 0);
    chk("async_cnt1", 32'(cnt1), 1);
    chk("async_lfsr1", 32'(lfsr1), 1);
    chk("async_rnd1", 32'(rnd1), 1);
    cycle(1, 1, 1, 0, 0, 0);
    repeat (20) cycle(0, 1, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ru = ($urandom_range(0, 19) != 0);
      e  = ($urandom_range(0, 3) != 0);
      if (m_on[0] && m_cnt[0] == 0 && $urandom_range(0, 1) == 1)
        w = 1'b1;
      else
        w = ($urandom_range(0, 19) == 0);
      p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                       : int'($urandom_range(0, 5));
      md = 1'($urandom_range(0, 1));
      cycle(r, ru, e, w, p, md);
    end

    @(posedge clk);
    #2;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain left %0d/%0d entries", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule
